// File: rtl/sun_trb_sar_pkg.sv
// -----------------------------------------------------------------------------
// sun_trb_sar_pkg
// Shared definitions for the SAR ADC conversion sequencer:
//   - state_t      : sequencer FSM state encoding
//   - DEF_NBITS    : default conversion resolution
//   - DEF_NSAMPLE  : default number of cycles SAMPLE stays high
//   - DEF_TIMEOUT  : default comparator-decision watchdog length (cycles)
//   - TMR_W        : width of the loadable down-counters (sample/timeout)
// -----------------------------------------------------------------------------
package sun_trb_sar_pkg;

    localparam int DEF_NBITS   = 8;
    localparam int DEF_NSAMPLE = 2;
    localparam int DEF_TIMEOUT = 7;
    localparam int TMR_W       = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SMP  = 3'd1,
        ST_CMP  = 3'd2,
        ST_RST  = 3'd3,
        ST_FIN  = 3'd4
    } state_t;

endpackage

// File: rtl/sun_trb_sar_tmr.sv
// -----------------------------------------------------------------------------
// sun_trb_sar_tmr
// Loadable TMR_W-bit down-counter with a zero flag. Loading takes priority
// over counting; the count saturates at zero.
// Ports:
//   ck       in  clock
//   rn       in  synchronous active-low reset (count -> 0)
//   load     in  load load_val into the counter
//   load_val in  value to load
//   en       in  decrement enable
//   zero     out high while the count is zero
// -----------------------------------------------------------------------------
module sun_trb_sar_tmr
    import sun_trb_sar_pkg::*;
(
    input  logic             ck,
    input  logic             rn,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [TMR_W-1:0] cnt_reg;

    always_ff @(posedge ck) begin
        if (!rn) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (en && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - TMR_W'(1);
        end
    end

    assign zero = (cnt_reg == '0);

endmodule

// File: rtl/sun_trb_sar_seq.sv
// -----------------------------------------------------------------------------
// sun_trb_sar_seq
// Successive-approximation conversion sequencer. Samples the input for NSAMPLE
// cycles, then resolves NBITS bits MSB first: strobe the comparator, record
// the decision, drive the CDAC switch for that bit, wait for the comparator to
// release, move to the next bit. All outputs are registered.
//
// Optional feature: define SUN_TRB_SAR_TIMEOUT_EN to enable the comparator
// watchdog. A bit with no decision after TIMEOUT cycles of strobing is forced
// to 0 and the sticky TOUT flag is raised. Without it, CMP waits forever and
// tout is constant 0.
//
// Ports:
//   ck      in  clock
//   rn      in  synchronous active-low reset
//   start   in  conversion request (accepted only in IDLE, not with done)
//   cmp_p   in  comparator positive decision
//   cmp_n   in  comparator negative decision (both high = no decision)
//   sample  out CDAC track-switch enable
//   cmp_ck  out comparator strobe
//   cp      out CDAC switch controls, P side
//   cn      out CDAC switch controls, N side
//   dout    out result of the last completed conversion
//   done    out one-cycle pulse on result update
//   busy    out high in every state except IDLE
//   tout    out sticky comparator-timeout flag
// -----------------------------------------------------------------------------
module sun_trb_sar_seq
    import sun_trb_sar_pkg::*;
#(
    parameter int NBITS   = DEF_NBITS,
    parameter int NSAMPLE = DEF_NSAMPLE,
    parameter int TIMEOUT = DEF_TIMEOUT
)
(
    input  logic             ck,
    input  logic             rn,
    input  logic             start,
    input  logic             cmp_p,
    input  logic             cmp_n,
    output logic             sample,
    output logic             cmp_ck,
    output logic [NBITS-1:0] cp,
    output logic [NBITS-1:0] cn,
    output logic [NBITS-1:0] dout,
    output logic             done,
    output logic             busy,
    output logic             tout
);

    localparam int              KW       = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam logic [KW-1:0]   K_TOP    = KW'(NBITS - 1);
    localparam logic [TMR_W-1:0] SMP_LOAD = TMR_W'(NSAMPLE - 1);

    // Both timers are TMR_W bits wide; reject settings they cannot count.
    if (NSAMPLE < 1 || NSAMPLE > 15 || TIMEOUT < 1 || TIMEOUT > 15) begin : g_bad_param
        $error("sun_trb_sar_seq: NSAMPLE and TIMEOUT must be in 1..15");
    end

    state_t           state_reg;
    logic [KW-1:0]    k_reg;
    logic [NBITS-1:0] res_reg;
    logic [NBITS-1:0] cp_reg;
    logic [NBITS-1:0] cn_reg;
    logic [NBITS-1:0] dout_reg;
    logic             sample_reg;
    logic             cmp_ck_reg;
    logic             done_reg;
    logic             busy_reg;
    logic             tout_reg;

    // A START coinciding with the DONE pulse is dropped on purpose so a held
    // START cannot chain conversions back-to-back without a visible gap.
    logic start_ok;
    logic decision;
    logic cmp_idle;
    logic smp_zero;

    assign start_ok = (state_reg == ST_IDLE) && start && !done_reg;
    assign decision = cmp_p ^ cmp_n;
    assign cmp_idle = !cmp_p && !cmp_n;

    sun_trb_sar_tmr u_smp_tmr (
        .ck       (ck),
        .rn       (rn),
        .load     (start_ok),
        .load_val (SMP_LOAD),
        .en       (state_reg == ST_SMP),
        .zero     (smp_zero)
    );

`ifdef SUN_TRB_SAR_TIMEOUT_EN
    localparam logic [TMR_W-1:0] TMO_LOAD = TMR_W'(TIMEOUT - 1);

    logic tmo_zero;
    logic cmp_enter;

    // Reload the watchdog on every entry into CMP, from SMP or from RST.
    assign cmp_enter = ((state_reg == ST_SMP) && smp_zero) ||
                       ((state_reg == ST_RST) && cmp_idle && (k_reg != '0));

    sun_trb_sar_tmr u_tmo_tmr (
        .ck       (ck),
        .rn       (rn),
        .load     (cmp_enter),
        .load_val (TMO_LOAD),
        .en       (state_reg == ST_CMP),
        .zero     (tmo_zero)
    );
`endif

    always_ff @(posedge ck) begin
        if (!rn) begin
            state_reg  <= ST_IDLE;
            k_reg      <= '0;
            res_reg    <= '0;
            cp_reg     <= '0;
            cn_reg     <= '0;
            dout_reg   <= '0;
            sample_reg <= 1'b0;
            cmp_ck_reg <= 1'b0;
            done_reg   <= 1'b0;
            busy_reg   <= 1'b0;
            tout_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start_ok) begin
                        state_reg  <= ST_SMP;
                        k_reg      <= K_TOP;
                        cp_reg     <= '0;
                        cn_reg     <= '0;
                        sample_reg <= 1'b1;
                        busy_reg   <= 1'b1;
                        tout_reg   <= 1'b0;
                    end
                end
                ST_SMP: begin
                    if (smp_zero) begin
                        state_reg  <= ST_CMP;
                        sample_reg <= 1'b0;
                        cmp_ck_reg <= 1'b1;
                    end
                end
                ST_CMP: begin
                    if (decision) begin
                        res_reg[k_reg] <= cmp_p;
                        if (cmp_p) begin
                            cn_reg[k_reg] <= 1'b1;
                        end else begin
                            cp_reg[k_reg] <= 1'b1;
                        end
                        cmp_ck_reg <= 1'b0;
                        state_reg  <= ST_RST;
                    end
`ifdef SUN_TRB_SAR_TIMEOUT_EN
                    else if (tmo_zero) begin
                        // Silent comparator: resolve the bit as 0.
                        res_reg[k_reg] <= 1'b0;
                        cp_reg[k_reg]  <= 1'b1;
                        tout_reg       <= 1'b1;
                        cmp_ck_reg     <= 1'b0;
                        state_reg      <= ST_RST;
                    end
`endif
                end
                ST_RST: begin
                    // Wait for the comparator to release before the next strobe.
                    if (cmp_idle) begin
                        if (k_reg == '0) begin
                            state_reg <= ST_FIN;
                        end else begin
                            k_reg      <= k_reg - KW'(1);
                            cmp_ck_reg <= 1'b1;
                            state_reg  <= ST_CMP;
                        end
                    end
                end
                ST_FIN: begin
                    dout_reg  <= res_reg;
                    done_reg  <= 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign sample = sample_reg;
    assign cmp_ck = cmp_ck_reg;
    assign cp     = cp_reg;
    assign cn     = cn_reg;
    assign dout   = dout_reg;
    assign done   = done_reg;
    assign busy   = busy_reg;
    assign tout   = tout_reg;

endmodule

// File: doc/sun_trb_sar_seq.md
SUN_TRB_SAR_SEQ -- requirements
Module: sun_trb_sar_seq

Interface
REQ-001 Parameter NBITS, default 8, conversion resolution and width of the CDAC control buses.
REQ-002 Parameter NSAMPLE, default 2, number of cycles the SAMPLE output stays high (range 1-15).
REQ-003 Parameter TIMEOUT, default 7, maximum cycles to wait for a comparator decision (range 1-15).
REQ-004 CK  in  1  single clock; all state updates on the rising edge.
REQ-005 RN  in  1  reset, synchronous and active-low.
REQ-006 START  in  1  conversion request, sampled only in IDLE.
REQ-007 CMP_P  in  1  comparator positive decision.
REQ-008 CMP_N  in  1  comparator negative decision.
REQ-009 SAMPLE  out  1  CDAC track-switch enable.
REQ-010 CMP_CK  out  1  comparator strobe.
REQ-011 CP  out  NBITS  CDAC switch controls, P side, one bit per switch driver.
REQ-012 CN  out  NBITS  CDAC switch controls, N side, one bit per switch driver.
REQ-013 DOUT  out  NBITS  result of the last completed conversion.
REQ-014 DONE  out  1  one-cycle pulse marking a result update.
REQ-015 BUSY  out  1  high in every state except IDLE.
REQ-016 TOUT  out  1  sticky comparator-timeout flag.

Function
REQ-017 The FSM SHALL have the states IDLE, SMP, CMP, RST and FIN, and all outputs SHALL be registered.
REQ-018 In IDLE, START=1 SHALL move the FSM to SMP at the next edge, clear CP/CN to 0 and set the bit index k to NBITS-1.
REQ-019 In SMP, SAMPLE=1 for exactly NSAMPLE cycles, then the FSM SHALL move to CMP.
REQ-020 In CMP, CMP_CK=1; a decision is exactly one of CMP_P or CMP_N high, and both high SHALL count as no decision.
REQ-021 On a decision the FSM SHALL store DOUT_reg[k]=CMP_P, set CN[k]=1 if CMP_P else CP[k]=1, and move to RST with CMP_CK=0.
REQ-022 In RST, once CMP_P=CMP_N=0 the FSM SHALL decrement k and go to CMP, or go to FIN if k was 0.
REQ-023 In FIN, DOUT SHALL load the result register, DONE SHALL pulse for one cycle, and the FSM SHALL return to IDLE.
REQ-024 With a comparator that responds and clears one cycle after the strobe edge, a conversion SHALL take NSAMPLE + 4*NBITS + 1 cycles from START to DONE.
REQ-025 START while BUSY SHALL be ignored; START in the same cycle as DONE SHALL also be ignored.
REQ-026 DOUT SHALL hold its value between conversions.
REQ-027 CP and CN SHALL never both be 1 for the same bit index.

Reset
REQ-028 While RN=0 at an edge, the FSM SHALL enter IDLE and SAMPLE, CMP_CK, CP, CN, DOUT, DONE, BUSY, TOUT and all counters SHALL be 0.
REQ-029 Reset mid-conversion SHALL abort the conversion with no DONE pulse.

Configuration
REQ-030 The macro SUN_TRB_SAR_TIMEOUT_EN SHALL control the comparator-timeout watchdog.
REQ-031 With SUN_TRB_SAR_TIMEOUT_EN defined: if no decision arrives within TIMEOUT cycles in CMP, the bit SHALL be forced to 0 (CP[k]=1), TOUT SHALL be set, and the FSM SHALL go to RST.
REQ-032 TOUT SHALL clear only on reset or on START accepted in IDLE.
REQ-033 Without SUN_TRB_SAR_TIMEOUT_EN: CMP SHALL wait indefinitely and TOUT SHALL be constant 0.

Structure
REQ-034 The package sun_trb_sar_pkg SHALL hold the state enum, default NBITS/NSAMPLE/TIMEOUT constants and the 4-bit timer width.
REQ-035 The sub-module sun_trb_sar_tmr (loadable 4-bit down-counter with zero flag) SHALL provide both the sample timer and the timeout timer.

Verification
REQ-036 Ideal comparator with input code 0xA5, START pulse -> DONE at cycle NSAMPLE+33=35, DOUT=0xA5, CN=0xA5, CP=0x5A, TOUT=0.
REQ-037 START held high continuously across two conversions -> exactly two DONE pulses; no START accepted while BUSY.
REQ-038 RN=0 during bit 3 of a conversion -> all outputs 0 the next cycle, no DONE, previous DOUT lost (0).
REQ-039 CMP_P=CMP_N=1 held for 3 cycles, then CMP_P=1 -> both-high treated as no decision, bit stored as 1, conversion completes.
REQ-040 With the macro defined, comparator silent on bit 5 -> after 7 cycles DOUT[5]=0, TOUT=1, DONE still pulses, and the next START clears TOUT.
REQ-041 Without the macro, a silent comparator -> FSM stays in CMP with CMP_CK=1 for 100 cycles and TOUT=0.
